// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register carrying pc/ctrl/data with valid/ready,
// synchronous flush and an optional 2-entry skid buffer.
// Ports: clk, reset (async, high); in_valid/in_ready/in_pc/in_ctrl/in_data
// upstream; flush; out_valid/out_ready/out_pc/out_ctrl/out_data downstream;
// occupancy = beats held.
module pipe_stage_elastic #(
  parameter int          DATA_W   = 64,
  parameter int          CTRL_W   = 8,
  parameter logic [31:0] PC_RESET = 32'h80000000,
  parameter int          SKID     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [31:0]       main_pc;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  logic              out_xfer;

  assign out_pc   = main_pc;
  assign out_data = main_data;
  // A bubble must never present a live write-enable downstream.
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  if (SKID == 0) begin : g_single
    logic vld;

    assign out_valid = vld;
    assign in_ready  = !vld | out_ready;
    assign occupancy = {1'b0, vld};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld       <= 1'b0;
        main_pc   <= PC_RESET;
        main_ctrl <= '0;
        main_data <= '0;
      end else if (flush) begin
        vld <= 1'b0;
      end else if (in_xfer) begin
        vld       <= 1'b1;
        main_pc   <= in_pc;
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (out_xfer) begin
        vld <= 1'b0;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              rdy;
    logic [31:0]       skid_pc;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // in_ready comes straight from a flop so out_ready never
    // reaches the upstream stage combinationally.
    assign in_ready  = rdy;
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= EMPTY;
        rdy       <= 1'b1;
        main_pc   <= PC_RESET;
        main_ctrl <= '0;
        main_data <= '0;
        skid_pc   <= '0;
        skid_ctrl <= '0;
        skid_data <= '0;
      end else if (flush) begin
        state <= EMPTY;
        rdy   <= 1'b1;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_xfer) begin
              main_pc   <= in_pc;
              main_ctrl <= in_ctrl;
              main_data <= in_data;
              state     <= ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_pc   <= in_pc;
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else if (in_xfer) begin
              skid_pc   <= in_pc;
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
              state     <= TWO;
              rdy       <= 1'b0;
            end else if (out_xfer) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (out_xfer) begin
              main_pc   <= skid_pc;
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
              state     <= ONE;
              rdy       <= 1'b1;
            end
          end
          default: begin
            state <= EMPTY;
            rdy   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: SKID=0 and SKID=1 instances side by side,
// checked every cycle against a FIFO-queue reference model.
module tb_pipe_stage_elastic;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam logic [31:0] PCR = 32'h80000000;

  typedef struct {
    logic [31:0] pc;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [31:0] pc;
  logic [CW-1:0] ctrl;
  logic [DW-1:0] data;
  logic [1:0] iv;
  logic [1:0] ordy;
  logic [1:0] ir;
  logic [1:0] ov;
  logic [31:0] opc [2];
  logic [CW-1:0] octl [2];
  logic [DW-1:0] odat [2];
  logic [1:0] occ [2];

  int checks = 0;
  int errors = 0;

  beat_t q [2][$];
  beat_t last [2];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .PC_RESET(PCR), .SKID(0)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_pc(pc), .in_ctrl(ctrl), .in_data(data),
    .flush(flush),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_pc(opc[0]), .out_ctrl(octl[0]), .out_data(odat[0]),
    .occupancy(occ[0])
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .PC_RESET(PCR), .SKID(1)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_pc(pc), .in_ctrl(ctrl), .in_data(data),
    .flush(flush),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_pc(opc[1]), .out_ctrl(octl[1]), .out_data(odat[1]),
    .occupancy(occ[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream acceptance from the queue depth alone.
  function automatic bit m_ready(input int k);
    if (k == 0) return (q[0].size() == 0) || ordy[0];
    return q[1].size() < 2;
  endfunction

  function automatic beat_t m_head(input int k);
    if (q[k].size() > 0) return q[k][0];
    return last[k];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      last[k] = '{pc: PCR, ctrl: '0, data: '0};
    end
  endtask

  task automatic chk_out();
    beat_t h;
    bit v;
    for (int k = 0; k < 2; k++) begin
      h = m_head(k);
      v = q[k].size() > 0;
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(v));
      chk($sformatf("out_pc%0d", k), 64'(opc[k]), 64'(h.pc));
      chk($sformatf("out_ctrl%0d", k), 64'(octl[k]),
          v ? 64'(h.ctrl) : 64'd0);
      chk($sformatf("out_data%0d", k), odat[k], h.data);
      chk($sformatf("occ%0d", k), 64'(occ[k]), 64'(q[k].size()));
    end
  endtask

  task automatic step(input bit v0, input bit r0, input bit v1,
                      input bit r1, input bit fl,
                      input logic [31:0] p, input logic [CW-1:0] c,
                      input logic [DW-1:0] d);
    bit xin [2];
    bit xout [2];
    logic save;
    beat_t b;
    chk_out();
    iv = {v1, v0};
    ordy = {r1, r0};
    flush = fl;
    pc = p;
    ctrl = c;
    data = d;
    #1;
    chk("in_ready0", 64'(ir[0]), 64'(m_ready(0)));
    chk("in_ready1", 64'(ir[1]), 64'(m_ready(1)));
    save = ir[1];
    ordy[1] = ~ordy[1];
    #1;
    chk("in_ready1_comb", 64'(ir[1]), 64'(save));
    ordy[1] = ~ordy[1];
    #1;
    b = '{pc: p, ctrl: c, data: d};
    for (int k = 0; k < 2; k++) begin
      xin[k] = iv[k] && m_ready(k);
      xout[k] = (q[k].size() > 0) && ordy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (fl) q[k].delete();
      else begin
        if (xout[k]) void'(q[k].pop_front());
        if (xin[k]) q[k].push_back(b);
      end
      if (q[k].size() > 0) last[k] = q[k][0];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 1, 0, 32'h0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    iv = '0;
    ordy = '0;
    pc = '0;
    ctrl = '0;
    data = '0;
    m_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      step(1, 1, 1, 1, 0, 32'h1000 + 32'(4 * i), CW'(i),
           DW'(64'hA5A5_0000_0000_0000 + 64'(i)));
    idle(3);

    step(0, 1, 1, 0, 0, 32'h10, 8'h11, 64'h10);
    step(0, 1, 1, 0, 0, 32'h14, 8'h12, 64'h14);
    step(0, 1, 1, 0, 0, 32'h18, 8'h13, 64'h18);
    chk("bp_main_pc", 64'(opc[1]), 64'h10);
    chk("bp_occ", 64'(occ[1]), 64'd2);
    chk("bp_in_ready", 64'(ir[1]), 64'd0);
    step(0, 1, 1, 1, 0, 32'h18, 8'h13, 64'h18);
    chk("bp_drain1", 64'(opc[1]), 64'h14);
    step(0, 1, 1, 1, 0, 32'h18, 8'h13, 64'h18);
    chk("bp_drain2", 64'(opc[1]), 64'h18);
    idle(2);

    step(0, 1, 1, 0, 0, 32'h30, 8'h21, 64'h30);
    step(0, 1, 1, 0, 0, 32'h34, 8'h22, 64'h34);
    step(1, 0, 1, 0, 1, 32'h20, 8'hFF, 64'h20);
    chk("fl_valid", 64'(ov[1]), 64'd0);
    chk("fl_ctrl", 64'(octl[1]), 64'd0);
    chk("fl_occ", 64'(occ[1]), 64'd0);
    chk("fl_ready", 64'(ir[1]), 64'd1);
    idle(3);

    step(1, 1, 1, 1, 0, 32'h40, 8'h01, 64'h40);
    step(0, 1, 0, 1, 0, 32'h44, 8'h01, 64'h44);
    chk("bub_ctrl0", 64'(octl[0]), 64'd0);
    chk("bub_pc0", 64'(opc[0]), 64'h40);
    chk("bub_ctrl1", 64'(octl[1]), 64'd0);

    step(0, 0, 1, 0, 0, 32'h50, 8'h31, 64'h50);
    step(1, 0, 1, 0, 0, 32'h54, 8'h32, 64'h54);
    iv = '0;
    ordy = '0;
    #2 reset = 1'b1;
    #1;
    m_reset();
    chk_out();
    chk("rst_ready0", 64'(ir[0]), 64'd1);
    chk("rst_ready1", 64'(ir[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 63) == 0, $urandom, CW'($urandom),
           {$urandom, $urandom});
    chk_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
